multi_pattern_generator: RTL and testbench

Parametrised multi-mode video test source that streams frames into the display-side pixel queue in place of the camera path. It supports any frame size, a selectable pattern (colour bars, grey ramp, checkerboard, solid colour) and optional in-band frame/row markers. It respects queue back-pressure without dropping or duplicating words. An optional frame counter animates the checkerboard for motion and tearing checks.

---
 rtl/multi_pattern_generator_if.sv | 26 ++
 rtl/multi_pattern_generator.sv | 139 +++++++++++++
 tb/tb_multi_pattern_generator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_pattern_generator_if.sv
// multi_pattern_generator_if: pixel-queue bus between the pattern generator and the display-side queue
// Signals:
//   enable, mode[1:0], solid_color[15:0]  controls into the generator
//   queue_full                            back-pressure from the queue
//   queue_data[16:0], queue_wr_en         word stream (bit16 = marker flag)
//   queue_clk, busy, frame_count[7:0]     status from the generator
// Modports: master = generator side, slave = queue/controller side.
interface multi_pattern_generator_if;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        queue_full;
  logic [16:0] queue_data;
  logic        queue_wr_en;
  logic        queue_clk;
  logic        busy;
  logic [7:0]  frame_count;
  modport master (
    input  enable, mode, solid_color, queue_full,
    output queue_data, queue_wr_en, queue_clk, busy, frame_count
  );
  modport slave (
    output enable, mode, solid_color, queue_full,
    input  queue_data, queue_wr_en, queue_clk, busy, frame_count
  );
endinterface

// File: rtl/multi_pattern_generator.sv
// multi_pattern_generator: test-pattern video source streaming frames into the display pixel queue
// Ports:
//   clk      pixel/queue clock
//   reset_n  asynchronous active-low reset
//   bus      multi_pattern_generator_if.master (enable, mode, solid_color, queue_full in;
//            queue_data, queue_wr_en, queue_clk, busy, frame_count out)
// Optional feature: define PATTERN_ANIMATION_EN to enable the frame counter and the
// checkerboard phase that inverts every frame; otherwise frame_count is held at 0.
module multi_pattern_generator #(
  parameter int FRAME_WIDTH   = 480,
  parameter int FRAME_HEIGHT  = 272,
  parameter int NUM_BARS      = 8,
  parameter int CHECKER_SHIFT = 4,
  parameter int SEND_MARKERS  = 1
) (
  input logic clk,
  input logic reset_n,
  multi_pattern_generator_if.master bus
);
  typedef enum logic [2:0] {IDLE, FRAME_START, ROW_START, PIXELS, FRAME_END} state_t;
  localparam int   BAR_W = (FRAME_WIDTH / NUM_BARS) < 1 ? 1 : FRAME_WIDTH / NUM_BARS;
  localparam logic MK    = SEND_MARKERS != 0;
  localparam logic [7:0][15:0] PAL = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                      16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
  state_t      state_q, state_d;
  logic [10:0] col_q, col_d, row_q, row_d, bar_col_q, bar_col_d;
  logic [2:0]  bar_q, bar_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] solid_q, solid_d;
  logic [16:0] data_q, data_d;
  logic        wr_q, wr_d, busy_q, busy_d;
  logic        phase, emit, last_col, last_row, ck;
  logic [7:0]  g;
  logic [15:0] rgb;
  logic [16:0] word;
  assign g        = col_q[7:0];
  assign ck       = col_q[CHECKER_SHIFT] ^ row_q[CHECKER_SHIFT] ^ phase;
  assign rgb      = mode_q == 2'd0 ? PAL[bar_q] :
                    mode_q == 2'd1 ? {g[7:3], g[7:2], g[7:3]} :
                    mode_q == 2'd2 ? {16{ck}} : solid_q;
  assign word     = state_q == FRAME_START ? 17'h10000 :
                    state_q == ROW_START   ? 17'h10001 :
                    state_q == FRAME_END   ? 17'h1FFFF : {1'b0, rgb};
  // Every non-idle state has exactly one word pending; it goes out only when the queue has room.
  assign emit     = state_q != IDLE && !bus.queue_full;
  assign last_col = col_q == 11'(FRAME_WIDTH - 1);
  assign last_row = row_q == 11'(FRAME_HEIGHT - 1);
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    bar_d     = bar_q;
    bar_col_d = bar_col_q;
    mode_d    = mode_q;
    solid_d   = solid_q;
    wr_d      = emit;
    data_d    = emit ? word : data_q;
    busy_d    = emit || (busy_q && state_q != IDLE);
    if (state_q == IDLE && bus.enable) begin
      state_d   = MK ? FRAME_START : PIXELS;
      mode_d    = bus.mode;
      solid_d   = bus.solid_color;
      col_d     = '0;
      row_d     = '0;
      bar_d     = '0;
      bar_col_d = '0;
    end else if (emit) begin
      case (state_q)
        FRAME_START: state_d = ROW_START;
        ROW_START:   state_d = PIXELS;
        FRAME_END:   state_d = IDLE;
        PIXELS: begin
          if (last_col) begin
            col_d     = '0;
            bar_d     = '0;
            bar_col_d = '0;
            if (last_row) state_d = MK ? FRAME_END : IDLE;
            else begin
              row_d   = row_q + 11'd1;
              state_d = MK ? ROW_START : PIXELS;
            end
          end else begin
            col_d = col_q + 11'd1;
            // The last bar never advances, so it soaks up the remainder columns.
            if (bar_col_q == 11'(BAR_W - 1) && bar_q != 3'(NUM_BARS - 1)) begin
              bar_d     = bar_q + 3'd1;
              bar_col_d = '0;
            end else bar_col_d = bar_col_q + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      bar_q     <= '0;
      bar_col_q <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      bar_q     <= bar_d;
      bar_col_q <= bar_col_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
    end
  end
`ifdef PATTERN_ANIMATION_EN
  logic [7:0] frame_count_q, frame_count_d;
  // A frame completes on the end marker, or on the last pixel when markers are off.
  assign frame_count_d = frame_count_q + 8'(emit && (state_q == FRAME_END ||
                         (!MK && state_q == PIXELS && last_col && last_row)));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_count_q <= '0;
    else frame_count_q <= frame_count_d;
  end
  assign phase           = frame_count_q[0];
  assign bus.frame_count = frame_count_q;
`else
  assign phase           = 1'b0;
  assign bus.frame_count = '0;
`endif
  assign bus.queue_data  = data_q;
  assign bus.queue_wr_en = wr_q;
  assign bus.busy        = busy_q;
  assign bus.queue_clk   = clk;
endmodule

// File: tb/tb_multi_pattern_generator.sv
// tb_multi_pattern_generator: directed self-checking bench for multi_pattern_generator
module tb_multi_pattern_generator;
  logic clk = 1'b0;
  logic rn;
  int   total = 0;
  int   bad = 0;
  int   viol = 0;
  logic full_s = 1'b0;
  logic [16:0] cap0[$];
  logic [16:0] cap1[$];
  logic [16:0] cap2[$];
  logic [16:0] exp_q[$];
  logic [15:0] pal [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  always #5 clk = ~clk;
  multi_pattern_generator_if ia();
  multi_pattern_generator_if ib();
  multi_pattern_generator_if ic();
  multi_pattern_generator #(.FRAME_WIDTH(16), .FRAME_HEIGHT(4), .NUM_BARS(4),
    .CHECKER_SHIFT(2), .SEND_MARKERS(1)) u0 (.clk(clk), .reset_n(rn), .bus(ia.master));
  multi_pattern_generator #(.FRAME_WIDTH(300), .FRAME_HEIGHT(2), .NUM_BARS(8),
    .CHECKER_SHIFT(4), .SEND_MARKERS(0)) u1 (.clk(clk), .reset_n(rn), .bus(ib.master));
  multi_pattern_generator #(.FRAME_WIDTH(10), .FRAME_HEIGHT(1), .NUM_BARS(3),
    .CHECKER_SHIFT(4), .SEND_MARKERS(1)) u2 (.clk(clk), .reset_n(rn), .bus(ic.master));
  always @(posedge clk) full_s <= ia.queue_full;
  always @(negedge clk) begin
    if (ia.queue_wr_en) cap0.push_back(ia.queue_data);
    if (ib.queue_wr_en) cap1.push_back(ib.queue_data);
    if (ic.queue_wr_en) cap2.push_back(ic.queue_data);
    if (ia.queue_wr_en && full_s) viol++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic logic [16:0] pick(input logic [16:0] q[$], input int i);
    return i < q.size() ? q[i] : 17'hx;
  endfunction
  task automatic mk_bars(input int w, input int h, input int nb);
    int b;
    exp_q.delete();
    exp_q.push_back(17'h10000);
    for (int r = 0; r < h; r++) begin
      exp_q.push_back(17'h10001);
      for (int c = 0; c < w; c++) begin
        b = c / (w / nb);
        if (b > nb - 1) b = nb - 1;
        exp_q.push_back({1'b0, pal[b]});
      end
    end
    exp_q.push_back(17'h1FFFF);
  endtask
  task automatic cmp_stream(input string tag, input logic [16:0] got[$]);
    int mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) mism++;
    chk({tag, "_len"}, got.size(), exp_q.size());
    chk({tag, "_mism"}, mism, 0);
  endtask
  initial begin
    rn = 1'b0;
    {ia.enable, ia.mode, ia.solid_color, ia.queue_full} = '0;
    {ib.enable, ib.mode, ib.solid_color, ib.queue_full} = '0;
    {ic.enable, ic.mode, ic.solid_color, ic.queue_full} = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", ia.queue_data, 17'h0);
    chk("rst_wr", ia.queue_wr_en, 1'b0);
    chk("rst_busy", ia.busy, 1'b0);
    chk("rst_fc", ia.frame_count, 8'd0);
    chk("qclk", ia.queue_clk, clk);
    rn = 1'b1;
    repeat (2) @(negedge clk);
    // bars with markers, latency, enable dropped mid-frame
    cap0.delete();
    ia.mode = 2'd0;
    ia.enable = 1'b1;
    @(negedge clk);
    chk("lat_1", ia.queue_wr_en, 1'b0);
    @(negedge clk);
    chk("lat_2_wr", ia.queue_wr_en, 1'b1);
    chk("lat_2_data", ia.queue_data, 17'h10000);
    chk("lat_2_busy", ia.busy, 1'b1);
    ia.enable = 1'b0;
    repeat (100) @(negedge clk);
    mk_bars(16, 4, 4);
    cmp_stream("bars", cap0);
    chk("bars_busy_low", ia.busy, 1'b0);
`ifdef PATTERN_ANIMATION_EN
    chk("bars_fc", ia.frame_count, 8'd1);
`else
    chk("bars_fc", ia.frame_count, 8'd0);
`endif
    repeat (20) @(negedge clk);
    chk("no_more_writes", cap0.size(), 70);
    // back-pressure
    cap0.delete();
    viol = 0;
    ia.enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      ia.queue_full = 1'($urandom_range(0, 1));
      if (i == 5) ia.enable = 1'b0;
    end
    ia.queue_full = 1'b0;
    repeat (20) @(negedge clk);
    cmp_stream("bp", cap0);
    chk("bp_viol", viol, 0);
    // solid colour latched at frame start
    cap0.delete();
    ia.mode = 2'd3;
    ia.solid_color = 16'h1234;
    ia.enable = 1'b1;
    repeat (3) @(negedge clk);
    ia.enable = 1'b0;
    ia.solid_color = 16'hABCD;
    ia.mode = 2'd0;
    repeat (100) @(negedge clk);
    chk("solid_len", cap0.size(), 70);
    chk("solid_row", pick(cap0, 1), 17'h10001);
    chk("solid_first", pick(cap0, 2), 17'h01234);
    chk("solid_last", pick(cap0, 68), 17'h01234);
    chk("solid_end", pick(cap0, 69), 17'h1FFFF);
    // remainder bar
    ic.enable = 1'b1;
    repeat (3) @(negedge clk);
    ic.enable = 1'b0;
    repeat (40) @(negedge clk);
    mk_bars(10, 1, 3);
    cmp_stream("rem", cap2);
    chk("rem_last_bar", pick(cap2, 11), 17'h007FF);
    // grey ramp without markers
    ib.mode = 2'd1;
    ib.enable = 1'b1;
    @(negedge clk);
    chk("ramp_lat_1", ib.queue_wr_en, 1'b0);
    @(negedge clk);
    chk("ramp_lat_2", ib.queue_wr_en, 1'b1);
    ib.enable = 1'b0;
    repeat (700) @(negedge clk);
    chk("ramp_len", cap1.size(), 600);
    chk("ramp_c0", pick(cap1, 0), 17'h00000);
    chk("ramp_c128", pick(cap1, 128), 17'h08410);
    chk("ramp_c255", pick(cap1, 255), 17'h0FFFF);
    chk("ramp_c256", pick(cap1, 256), 17'h00000);
    chk("ramp_c299", pick(cap1, 299), 17'h02945);
    chk("ramp_r1c255", pick(cap1, 555), 17'h0FFFF);
`ifdef PATTERN_ANIMATION_EN
    chk("ramp_fc", ib.frame_count, 8'd1);
`else
    chk("ramp_fc", ib.frame_count, 8'd0);
`endif
    // checker over two frames, counter from zero
    rn = 1'b0;
    repeat (2) @(negedge clk);
    rn = 1'b1;
    @(negedge clk);
    cap0.delete();
    ia.mode = 2'd2;
    ia.enable = 1'b1;
    repeat (80) @(negedge clk);
    ia.enable = 1'b0;
    repeat (150) @(negedge clk);
    chk("chk_len", cap0.size(), 140);
    chk("chk_f0_p00", pick(cap0, 2), 17'h00000);
    chk("chk_f0_p40", pick(cap0, 6), 17'h0FFFF);
    chk("chk_f1_start", pick(cap0, 70), 17'h10000);
`ifdef PATTERN_ANIMATION_EN
    chk("chk_f1_p00", pick(cap0, 72), 17'h0FFFF);
    chk("chk_f1_p40", pick(cap0, 76), 17'h00000);
    chk("chk_fc", ia.frame_count, 8'd2);
`else
    chk("chk_f1_p00", pick(cap0, 72), 17'h00000);
    chk("chk_f1_p40", pick(cap0, 76), 17'h0FFFF);
    chk("chk_fc", ia.frame_count, 8'd0);
`endif
    // reset mid-frame
    cap0.delete();
    ia.mode = 2'd0;
    ia.enable = 1'b1;
    for (int i = 0; i < 100 && cap0.size() < 30; i++) @(negedge clk);
    chk("mid_reached_30", cap0.size() >= 30, 1'b1);
    rn = 1'b0;
    #1;
    chk("mid_rst_wr", ia.queue_wr_en, 1'b0);
    chk("mid_rst_data", ia.queue_data, 17'h0);
    chk("mid_rst_busy", ia.busy, 1'b0);
    chk("mid_rst_fc", ia.frame_count, 8'd0);
    repeat (2) @(negedge clk);
    cap0.delete();
    rn = 1'b1;
    repeat (3) @(negedge clk);
    ia.enable = 1'b0;
    chk("mid_first", pick(cap0, 0), 17'h10000);
    repeat (100) @(negedge clk);
    mk_bars(16, 4, 4);
    cmp_stream("after_rst", cap0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
